// File: rtl/vga_pkg.sv
// vga_pkg: shared types and constants for the VGA pixel/data path.
package vga_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        RM_PASS,
        RM_BITREV,
        RM_BYTESWAP,
        RM_BITREV_BYTE
    } reorder_mode_t;

endpackage

// File: rtl/reorder_net.sv
// reorder_net: combinational word reorder (pass, bit reverse, byte swap, bit reverse per byte).
module reorder_net
    import vga_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  reorder_mode_t     mode,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] x
);

    localparam int NB = DATA_W / BYTE_W;

    if (DATA_W % BYTE_W != 0 || DATA_W < BYTE_W) begin : g_bad_width
        $error("reorder_net: DATA_W must be a multiple of 8 and at least 8");
    end

    logic [DATA_W-1:0] w_rev;
    logic [DATA_W-1:0] w_swap;
    logic [DATA_W-1:0] w_rbb;

    genvar i, k, j;
    for (i = 0; i < DATA_W; i++) begin : g_rev
        assign w_rev[i] = d[DATA_W-1-i];
    end

    for (k = 0; k < NB; k++) begin : g_byte
        for (j = 0; j < BYTE_W; j++) begin : g_bit
            assign w_swap[k*BYTE_W+j] = d[(NB-1-k)*BYTE_W+j];
            assign w_rbb[k*BYTE_W+j]  = d[k*BYTE_W+BYTE_W-1-j];
        end
    end

    always_comb begin
        x = (mode == RM_PASS)     ? d     :
            (mode == RM_BITREV)   ? w_rev :
            (mode == RM_BYTESWAP) ? w_swap : w_rbb;
    end

endmodule

// File: rtl/stream_bit_reorder.sv
// stream_bit_reorder: 2-stage elastic valid/ready pipeline applying a per-word reorder mode,
// with a saturating accepted-word counter.
module stream_bit_reorder
    import vga_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  word_cnt
);

    logic              r_s1_valid;
    logic [DATA_W-1:0] r_s1_data;
    reorder_mode_t     r_s1_mode;
    logic              r_s2_valid;
    logic [DATA_W-1:0] r_s2_data;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_s2_adv;
    logic              w_s1_adv;
    logic [DATA_W-1:0] w_net;

    // A stage loads whenever it is empty or its content moves on, so bubbles collapse.
    assign w_s2_adv = !r_s2_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;

    assign in_ready  = w_s1_adv;
    assign out_valid = r_s2_valid;
    assign out_data  = r_s2_data;
    assign word_cnt  = r_cnt;

    reorder_net #(.DATA_W(DATA_W)) u_net (
        .mode (r_s1_mode),
        .d    (r_s1_data),
        .x    (w_net)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_mode  <= RM_PASS;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_data <= in_data;
                r_s1_mode <= reorder_mode_t'(in_mode);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) r_s2_data <= w_net;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_cnt <= '0;
        else if (in_valid && in_ready && r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + 1'b1;
    end

endmodule
